// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the immediate/target extension pipe.
//   ext_op_e : mode select encodings seen on ext_op
//   occ_e    : occupancy states of the 2-entry output buffer
package mips_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    EXT_ZERO = 3'b000,
    EXT_SIGN = 3'b001,
    EXT_BR   = 3'b010,
    EXT_LUI  = 3'b011,
    EXT_JAL  = 3'b100,
    EXT_BTA  = 3'b101
  } ext_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ext_pipe_if.sv
// ext_pipe_if: request/response handshake bundle for ext_pipe.
//   request : in_valid, in_ready, ext_op, imm, instr_index, pc
//   response: out_valid, out_ready, ext_out, out_err
//   slave   : the ext_pipe view; master: the requester/consumer view
interface ext_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int J_W    = 26
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ext_op;
  logic [IMM_W-1:0]  imm;
  logic [J_W-1:0]    instr_index;
  logic [DATA_W-1:0] pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_out;
  logic              out_err;

  modport slave (
    input  in_valid, ext_op, imm, instr_index, pc, out_ready,
    output in_ready, out_valid, ext_out, out_err
  );

  modport master (
    output in_valid, ext_op, imm, instr_index, pc, out_ready,
    input  in_ready, out_valid, ext_out, out_err
  );
endinterface

// File: rtl/ext_core.sv
// ext_core: combinational immediate / jump-target extension decode.
//   ext_op      in  mode select (mips_pkg::ext_op_e encodings)
//   imm         in  immediate field
//   instr_index in  jump target field
//   pc          in  address of the instruction
//   result      out extended value (0 for illegal ops)
//   err         out illegal-op flag
// Macro EXT_BRANCH_TARGET_EN enables op EXT_BTA (pc + 4 + sext(imm) << 2);
// without it EXT_BTA decodes as illegal.
module ext_core
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int J_W    = 26
) (
  input  logic [OP_W-1:0]   ext_op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [J_W-1:0]    instr_index,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] sext_sh;
  logic [DATA_W-1:0] bta;

  assign sext    = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign sext_sh = {sext[DATA_W-3:0], 2'b00};

`ifdef EXT_BRANCH_TARGET_EN
  localparam bit BTA_EN = 1'b1;
  // Wraps modulo 2^DATA_W by construction.
  assign bta = pc + DATA_W'(4) + sext_sh;
`else
  localparam bit BTA_EN = 1'b0;
  logic unused_pc_lo;
  assign bta          = '0;
  assign unused_pc_lo = ^pc[J_W+1:0];
`endif

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (ext_op)
      EXT_ZERO: result = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SIGN: result = sext;
      EXT_BR:   result = sext_sh;
      EXT_LUI:  result = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_JAL:  result = {pc[DATA_W-1:J_W+2], instr_index, 2'b00};
      EXT_BTA: begin
        if (BTA_EN) result = bta;
        else        err    = 1'b1;
      end
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: extension decode followed by a 2-entry FIFO skid buffer.
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   flush in  synchronous discard of all buffered entries (beats push/pop)
//   bus   slave modport of ext_pipe_if (request and response handshakes)
// Macro EXT_BRANCH_TARGET_EN enables the branch-target op (see ext_core).
//
// state | meaning
// EMPTY | no entry buffered, out_valid low
// ONE   | head entry in slot 0
// TWO   | both slots full, in_ready low
module ext_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int J_W    = 26
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  ext_pipe_if.slave bus
);

  occ_e              state, state_nxt;
  logic              in_ready_q;
  logic              push, pop;
  logic [DATA_W-1:0] core_data, data0, data1;
  logic              core_err, err0, err1;

  ext_core #(.DATA_W(DATA_W), .IMM_W(IMM_W), .J_W(J_W)) u_core (
    .ext_op      (bus.ext_op),
    .imm         (bus.imm),
    .instr_index (bus.instr_index),
    .pc          (bus.pc),
    .result      (core_data),
    .err         (core_err)
  );

  // in_ready is registered from the next state so out_ready never reaches
  // it combinationally; it also stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
    end
  end

  always_comb begin
    push      = bus.in_valid && in_ready_q && !flush;
    pop       = (state != EMPTY) && bus.out_ready && !flush;
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = TWO;
          else if (pop && !push) state_nxt = EMPTY;
        end
        TWO:   if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Slot 0 is always the head; it only changes on a pop or when filling
  // an empty buffer, so the output holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0 <= '0;
      err0  <= 1'b0;
      data1 <= '0;
      err1  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            data0 <= core_data;
            err0  <= core_err;
          end
        end
        ONE: begin
          if (push && pop) begin
            data0 <= core_data;
            err0  <= core_err;
          end else if (push) begin
            data1 <= core_data;
            err1  <= core_err;
          end
        end
        TWO: begin
          if (pop) begin
            data0 <= data1;
            err0  <= err1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.ext_out   = data0;
  assign bus.out_err   = err0;

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int J_W    = 26;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  ext_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .J_W(J_W)) bus ();

  ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .J_W(J_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sb_idx   = 0;

  // Expected entries are {out_err, ext_out}.
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] cur_exp;
  logic [DATA_W:0] sb_e;

  task automatic chk(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Scoreboard: records accepted requests and checks delivered responses.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        sb_idx++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_out_%0d unexpected output actual=%h required=none", sb_idx, {bus.out_err, bus.ext_out});
        end else begin
          sb_e = exp_q.pop_front();
          chk($sformatf("sb_out_%0d", sb_idx), {bus.out_err, bus.ext_out}, sb_e);
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end
  end

  task automatic set_req(input logic [2:0] op, input logic [IMM_W-1:0] imm_v,
                         input logic [J_W-1:0] idx, input logic [DATA_W-1:0] pc_v,
                         input logic [DATA_W:0] expv);
    bus.in_valid    = 1'b1;
    bus.ext_op      = op;
    bus.imm         = imm_v;
    bus.instr_index = idx;
    bus.pc          = pc_v;
    cur_exp         = expv;
  endtask

  // Called just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [IMM_W-1:0] imm_v,
                      input logic [J_W-1:0] idx, input logic [DATA_W-1:0] pc_v,
                      input logic [DATA_W:0] expv);
    int n;
    set_req(op, imm_v, idx, pc_v, expv);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept_within_50");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.ext_op      = 3'b000;
    bus.imm         = '0;
    bus.instr_index = '0;
    bus.pc          = '0;
    bus.out_ready   = 1'b0;
    cur_exp         = '0;

    // Reset values
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_ext_out", {bus.out_err, bus.ext_out}, 33'h0_0000_0000);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("in_ready_after_reset", bus.in_ready, 1'b1);

    // Mode decode with a free-running consumer
    bus.out_ready = 1'b1;
    send(3'b000, 16'h8001, 26'h0, 32'h0, 33'h0_0000_8001);
    idle(2);
    send(3'b001, 16'h8001, 26'h0, 32'h0, 33'h0_FFFF_8001);
    chk1("latency_out_valid", bus.out_valid, 1'b1);
    chk("latency_ext_out", {bus.out_err, bus.ext_out}, 33'h0_FFFF_8001);
    send(3'b010, 16'h8001, 26'h0, 32'h0, 33'h0_FFFE_0004);
    send(3'b010, 16'h7FFF, 26'h0, 32'h0, 33'h0_0001_FFFC);
    send(3'b011, 16'h1234, 26'h0, 32'h0, 33'h0_1234_0000);
    send(3'b100, 16'h0, 26'h0000010, 32'hA000_0000, 33'h0_A000_0040);
    send(3'b100, 16'h0, 26'h3FF_FFFF, 32'h5FFF_FFFF, 33'h0_5FFF_FFFC);
    send(3'b110, 16'h1234, 26'h0, 32'h0, 33'h1_0000_0000);
    send(3'b111, 16'hFFFF, 26'h0, 32'hFFFF_FFFF, 33'h1_0000_0000);
`ifdef EXT_BRANCH_TARGET_EN
    send(3'b101, 16'h0000, 26'h0, 32'hFFFF_FFFC, 33'h0_0000_0000);
    send(3'b101, 16'hFFFF, 26'h0, 32'h1000_0000, 33'h0_1000_0000);
`else
    send(3'b101, 16'h0000, 26'h0, 32'hFFFF_FFFC, 33'h1_0000_0000);
    send(3'b101, 16'hFFFF, 26'h0, 32'h1000_0000, 33'h1_0000_0000);
`endif
    idle(3);

    // Backpressure: fill to TWO, hold a third request, release in order
    bus.out_ready = 1'b0;
    send(3'b000, 16'h0001, 26'h0, 32'h0, 33'h0_0000_0001);
    chk1("one_in_ready", bus.in_ready, 1'b1);
    send(3'b011, 16'h0001, 26'h0, 32'h0, 33'h0_0001_0000);
    chk1("two_in_ready", bus.in_ready, 1'b0);
    set_req(3'b010, 16'h0001, 26'h0, 32'h0, 33'h0_0000_0004);
    repeat (3) begin
      @(negedge clk);
      chk1("held_in_ready", bus.in_ready, 1'b0);
      chk1("held_out_valid", bus.out_valid, 1'b1);
      chk("held_ext_out", {bus.out_err, bus.ext_out}, 33'h0_0000_0001);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(3'b010, 16'h0001, 26'h0, 32'h0, 33'h0_0000_0004);
    idle(4);

    // Flush in TWO with a simultaneous request
    bus.out_ready = 1'b0;
    send(3'b000, 16'h0005, 26'h0, 32'h0, 33'h0_0000_0005);
    send(3'b000, 16'h0006, 26'h0, 32'h0, 33'h0_0000_0006);
    set_req(3'b000, 16'h0007, 26'h0, 32'h0, 33'h0_0000_0007);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk1("flush_two_out_valid", bus.out_valid, 1'b0);
    chk1("flush_two_in_ready", bus.in_ready, 1'b1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("after_flush_two_empty", bus.out_valid, 1'b0);
    end

    // Flush in ONE beats an acceptable push
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(3'b000, 16'h0008, 26'h0, 32'h0, 33'h0_0000_0008);
    set_req(3'b000, 16'h0009, 26'h0, 32'h0, 33'h0_0000_0009);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk1("flush_one_out_valid", bus.out_valid, 1'b0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("after_flush_one_empty", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    send(3'b001, 16'hFFFF, 26'h0, 32'h0, 33'h0_FFFF_FFFF);
    idle(3);

    // Asynchronous reset while in ONE
    bus.out_ready = 1'b0;
    send(3'b011, 16'hABCD, 26'h0, 32'h0, 33'h0_ABCD_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_out_valid", bus.out_valid, 1'b0);
    chk1("async_rst_in_ready", bus.in_ready, 1'b0);
    chk("async_rst_ext_out", {bus.out_err, bus.ext_out}, 33'h0_0000_0000);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("rerst_in_ready", bus.in_ready, 1'b1);
    chk1("rerst_out_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    send(3'b000, 16'h00FF, 26'h0, 32'h0, 33'h0_0000_00FF);
    idle(4);

    chk("sb_drained", (DATA_W+1)'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, output/datapath width; legal values are those satisfying both DATA_W >= IMM_W+2 and DATA_W >= J_W+3.
REQ-002 SHALL have parameter IMM_W, default 16, immediate field width.
REQ-003 SHALL have parameter J_W, default 26, jump instr_index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-007 SHALL have port in_valid  input  1  upstream offers a request.
REQ-008 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-009 SHALL have port ext_op  input  3  mode select (see REQ-014).
REQ-010 SHALL have port imm  input  IMM_W  immediate field.
REQ-011 SHALL have port instr_index  input  J_W  jump target field.
REQ-012 SHALL have port pc  input  DATA_W  address of the instruction.
REQ-013 SHALL have ports out_valid output 1; out_ready input 1; ext_out output DATA_W result; out_err output 1 illegal-op flag accompanying ext_out.

Function
REQ-014 SHALL compute per ext_op: 000 zero-extend imm; 001 sign-extend imm; 010 sign-extend imm shifted left 2; 011 {imm, zeros}; 100 {pc[DATA_W-1:J_W+2], instr_index, 2'b00}; 101 see REQ-025; 110/111 illegal.
REQ-015 SHALL, for an illegal op, produce ext_out = 0 and out_err = 1; legal ops SHALL produce out_err = 0.
REQ-016 SHALL register results in a 2-entry FIFO skid buffer; accept on in_valid && in_ready; deliver on out_valid && out_ready.
REQ-017 SHALL have latency exactly 1 cycle: a request accepted at edge N is visible on ext_out with out_valid = 1 after edge N when the buffer was empty.
REQ-018 SHALL use occupancy states EMPTY, ONE, TWO; in_ready = (state != TWO), registered, with no combinational path from out_ready.
REQ-019 SHALL transition EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; TWO->ONE on pop; no push is possible in TWO.
REQ-020 SHALL preserve strict FIFO order, and ext_out/out_err SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL, on flush, go to EMPTY at the next edge; flush takes priority over a simultaneous push or pop, and the pushed request is dropped.
REQ-022 SHALL compute all arithmetic modulo 2^DATA_W; REQ-025 addition wraps silently.

Reset
REQ-023 SHALL, while rst_n = 0, force state EMPTY, out_valid = 0, in_ready = 0, ext_out = 0, and out_err = 0, independent of clk.
REQ-024 SHALL raise in_ready on the first clk edge after rst_n deasserts; a reset mid-transfer discards all entries.

Configuration
REQ-025 SHALL, with macro EXT_BRANCH_TARGET_EN defined, implement op 101 as pc + 4 + (sign-extend imm << 2); without it, op 101 SHALL be treated as illegal per REQ-015.

Structure
REQ-026 SHALL take the ext_op encodings (EXT_ZERO, EXT_SIGN, EXT_BR, EXT_LUI, EXT_JAL, EXT_BTA) from shared package mips_pkg.
REQ-027 SHALL place the combinational mode decode in a sub-module ext_core, and keep the buffer state machine in ext_pipe.

Verification
REQ-028 SHALL cover: imm=16'h8001, op 001, out_ready=1 -> next cycle ext_out=32'hFFFF8001, out_err=0.
REQ-029 SHALL cover: pc=32'hA000_0000, instr_index=26'h0000_010, op 100 -> ext_out=32'hA000_0040.
REQ-030 SHALL cover: out_ready=0, three back-to-back pushes (ops 000/011/010, imm=16'h0001) -> in_ready=0 after the second push; the third is held; on release the outputs are 32'h0000_0001, 32'h0001_0000, 32'h0000_0004 in order.
REQ-031 SHALL cover: state TWO, flush=1 with in_valid=1 -> out_valid=0 and in_ready=1 next cycle; the pushed request is never output.
REQ-032 SHALL cover: op 101, pc=32'hFFFF_FFFC, imm=16'h0000 -> with EXT_BRANCH_TARGET_EN ext_out=32'h0000_0000 (wrap), out_err=0; without it ext_out=0, out_err=1.
REQ-033 SHALL cover: rst_n asserted low mid-cycle while in state ONE -> out_valid=0 immediately, without waiting for clk.
